// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter: round-robin owner selection for a shared 8:1 mux path.
// Build option MUXARB_TIMEOUT_EN adds a hold counter that forces a handover
// after MAX_HOLD owned cycles when someone else is waiting. Without it the
// owner keeps the path until it drops its request and preempt stays low.
//
// state    | meaning
// ---------+----------------------------------------------------
// ST_IDLE  | no owner; gnt, sel, sel_valid, preempt all zero
// ST_OWNED | exactly one gnt bit set, sel holds the owner index

module mux_sel_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       sel_valid,
    output logic       preempt
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_ptr;
    logic [7:0] r_gnt;
    logic [2:0] r_sel;
    logic       r_sel_valid;
    logic       r_preempt;

    logic [7:0] w_others;
    logic       w_owner_req;
    logic       w_timeout;
    logic       w_grant_new;
    logic [7:0] w_pool;
    logic [2:0] w_winner;
    logic [7:0] w_gnt_nxt;
    logic [2:0] w_sel_nxt;
    logic       w_valid_nxt;
    logic       w_preempt_nxt;

    // First set bit of pool scanning upward from start, wrapping 7 -> 0.
    function automatic logic [2:0] rr_pick(input logic [7:0] pool, input logic [2:0] start);
        logic [2:0] idx;
        logic       found;
        rr_pick = start;
        found   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = start + 3'(i);
            if (!found && pool[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    // Catch an out-of-range MAX_HOLD in simulation; synthesis ignores this.
    always_comb begin
        assert (MAX_HOLD >= 2 && MAX_HOLD <= 255);
    end

    assign w_owner_req = req[r_sel];
    assign w_others    = req & ~(8'd1 << r_sel);

`ifdef MUXARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] r_hold;

    // Hold counter: restarts on every grant, counts owned cycles, sticks at HOLD_LAST.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold <= 8'd0;
        end else if (w_grant_new) begin
            r_hold <= 8'd0;
        end else if (r_state == ST_OWNED && r_hold != HOLD_LAST) begin
            r_hold <= r_hold + 8'd1;
        end
    end

    // Forced handover only while the owner still wants the path and others wait.
    assign w_timeout = (r_state == ST_OWNED) && (r_hold == HOLD_LAST) &&
                       w_owner_req && (|w_others);
`else
    assign w_timeout = 1'b0;
`endif

    // State, pointer and registered outputs; reset clears all of them asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_ptr       <= 3'd0;
            r_gnt       <= 8'd0;
            r_sel       <= 3'd0;
            r_sel_valid <= 1'b0;
            r_preempt   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            if (w_grant_new) begin
                r_ptr <= w_winner + 3'd1;
            end
            r_gnt       <= w_gnt_nxt;
            r_sel       <= w_sel_nxt;
            r_sel_valid <= w_valid_nxt;
            r_preempt   <= w_preempt_nxt;
        end
    end

    // Next state and the request pool the round-robin scan picks from.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_new = 1'b0;
        w_pool      = req;
        case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_state_nxt = ST_OWNED;
                    w_grant_new = 1'b1;
                end
            end
            ST_OWNED: begin
                if (!w_owner_req) begin
                    w_pool = w_others;
                    if (|w_others) begin
                        w_grant_new = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_timeout) begin
                    w_pool      = w_others;
                    w_grant_new = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_winner = rr_pick(w_pool, r_ptr);

    // Next output values: cleared in idle, reloaded on a new grant, else held.
    always_comb begin
        w_gnt_nxt     = r_gnt;
        w_sel_nxt     = r_sel;
        w_valid_nxt   = r_sel_valid;
        w_preempt_nxt = 1'b0;
        if (w_state_nxt == ST_IDLE) begin
            w_gnt_nxt   = 8'd0;
            w_sel_nxt   = 3'd0;
            w_valid_nxt = 1'b0;
        end else if (w_grant_new) begin
            w_gnt_nxt     = 8'd1 << w_winner;
            w_sel_nxt     = w_winner;
            w_valid_nxt   = 1'b1;
            w_preempt_nxt = w_timeout;
        end
    end

    assign gnt       = r_gnt;
    assign sel       = r_sel;
    assign sel_valid = r_sel_valid;
    assign preempt   = r_preempt;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
module tb_mux_sel_arbiter;

    localparam int HOLD = 4;
`ifdef MUXARB_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       sel_valid;
    logic       preempt;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: owner index (-1 = nobody), next scan start, cycles owned so far
    int m_owner = -1;
    int m_ptr   = 0;
    int m_held  = 0;
    bit m_pre   = 1'b0;

    typedef struct {
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       valid;
        logic       pre;
    } vec_t;

    vec_t tbl [9];

    mux_sel_arbiter #(.MAX_HOLD(HOLD)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .gnt       (gnt),
        .sel       (sel),
        .sel_valid (sel_valid),
        .preempt   (preempt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] eg, input logic [2:0] es,
                             input logic ev, input logic ep);
        check($sformatf("%s gnt", tag), gnt, eg);
        check($sformatf("%s sel", tag), {5'd0, sel}, {5'd0, es});
        check($sformatf("%s sel_valid", tag), {7'd0, sel_valid}, {7'd0, ev});
        check($sformatf("%s preempt", tag), {7'd0, preempt}, {7'd0, ep});
    endtask

    function automatic int rr_scan(input logic [7:0] pool, input int start);
        for (int k = 0; k < 8; k++) begin
            if (pool[(start + k) % 8]) return (start + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_held  = 0;
        m_pre   = 1'b0;
    endtask

    task automatic model_grant(input int w);
        m_owner = w;
        m_ptr   = (w + 1) % 8;
        m_held  = 1;
    endtask

    task automatic model_step(input logic [7:0] r);
        logic [7:0] others;
        int         w;
        m_pre = 1'b0;
        if (m_owner < 0) begin
            w = rr_scan(r, m_ptr);
            if (w >= 0) model_grant(w);
        end else begin
            others          = r;
            others[m_owner] = 1'b0;
            if (!r[m_owner]) begin
                w = rr_scan(others, m_ptr);
                if (w >= 0) model_grant(w);
                else m_owner = -1;
            end else if (TIMEOUT_ON && m_held >= HOLD && others != 8'd0) begin
                model_grant(rr_scan(others, m_ptr));
                m_pre = 1'b1;
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [7:0] eg;
        logic [2:0] es;
        eg = (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
        es = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
        check_out(tag, eg, es, m_owner >= 0, m_pre);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(req);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req   = 8'd0;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int exp_o;
        logic [7:0] r_cur;

        tbl[0] = '{8'h85, 8'h01, 3'd0, 1'b1, 1'b0};
        tbl[1] = '{8'h85, 8'h01, 3'd0, 1'b1, 1'b0};
        tbl[2] = '{8'h84, 8'h04, 3'd2, 1'b1, 1'b0};
        tbl[3] = '{8'h85, 8'h04, 3'd2, 1'b1, 1'b0};
        tbl[4] = '{8'h81, 8'h80, 3'd7, 1'b1, 1'b0};
        tbl[5] = '{8'h85, 8'h80, 3'd7, 1'b1, 1'b0};
        tbl[6] = '{8'h05, 8'h01, 3'd0, 1'b1, 1'b0};
        tbl[7] = '{8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[8] = '{8'h00, 8'h00, 3'd0, 1'b0, 1'b0};

        reset = 1'b0;
        req   = 8'd0;
        #2 reset = 1'b1;
        #2 check_out("por", 8'd0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // idle after reset release
        for (int c = 0; c < 5; c++) begin
            tick();
            check_out($sformatf("idle c%0d", c), 8'd0, 3'd0, 1'b0, 1'b0);
        end

        // round-robin order 0,2,7,0 with single-cycle drops
        do_reset();
        for (int i = 0; i < 9; i++) begin
            req = tbl[i].req;
            tick();
            check_out($sformatf("rr row%0d", i), tbl[i].gnt, tbl[i].sel, tbl[i].valid, tbl[i].pre);
        end

        // lone owner never preempted
        do_reset();
        req = 8'h10;
        for (int c = 0; c < 20; c++) begin
            tick();
            check_out($sformatf("lone c%0d", c), 8'h10, 3'd4, 1'b1, 1'b0);
        end

`ifdef MUXARB_TIMEOUT_EN
        // two steady requesters: forced alternation every HOLD cycles
        do_reset();
        req = 8'h03;
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp_o = ((k - 1) / HOLD) % 2;
            check_out($sformatf("timeout k%0d", k), 8'd1 << exp_o, 3'(exp_o), 1'b1,
                      (k > 1) && ((k - 1) % HOLD == 0));
        end
`else
        // two steady requesters without timeout: owner 0 keeps the path
        do_reset();
        req = 8'h03;
        for (int c = 0; c < 30; c++) begin
            tick();
            check_out($sformatf("noto c%0d", c), 8'h01, 3'd0, 1'b1, 1'b0);
        end
`endif

        // async reset while owner 3 holds the grant
        do_reset();
        req = 8'h08;
        tick();
        check_out("own3", 8'h08, 3'd3, 1'b1, 1'b0);
        #2 reset = 1'b1;
        model_reset();
        #1 check_out("async_rst", 8'd0, 3'd0, 1'b0, 1'b0);
        #1;
        reset = 1'b0;
        req   = 8'h09;
        tick();
        check_out("post_rst", 8'h01, 3'd0, 1'b1, 1'b0);

        // randomized traffic against the reference model
        do_reset();
        r_cur = 8'd0;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
                r_cur = 8'd0;
            end
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 0) r_cur = 8'($urandom) & 8'($urandom);
                else r_cur = 8'($urandom);
            end
            req = r_cur;
            tick();
            check_model($sformatf("rand c%0d", c));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mux_sel_arbiter.md
MUX_SEL_ARBITER -- requirements
Module: mux_sel_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, default 16, maximum consecutive cycles one owner keeps the shared mux while others wait; legal range 2..255.
REQ-002 Port: clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 Port: reset, input, 1, asynchronous active-high reset.
REQ-004 Port: req, input, 8, bit i = requester i wants shared 8:1 mux path.
REQ-005 Port: gnt, output, 8, one-hot grant; all zero when idle.
REQ-006 Port: sel, output, 3, binary index of owner; bit 0 drives mux address0, bit 1 drives address1, bit 2 drives address2.
REQ-007 Port: sel_valid, output, 1, high when gnt is non-zero.
REQ-008 Port: preempt, output, 1, one-cycle pulse on forced handover by hold timeout.

Function
REQ-009 The block SHALL have two states: IDLE (no owner) and OWNED (exactly one gnt bit set).
REQ-010 gnt, sel, sel_valid and preempt SHALL be registered outputs; gnt SHALL never have more than one bit set.
REQ-011 Arbitration SHALL be round-robin: the winner is the first set req bit scanning upward from ptr, wrapping 7->0. ptr is a 3-bit register.
REQ-012 After every new grant, ptr SHALL load winner+1 modulo 8.
REQ-013 In IDLE with req non-zero at edge N, OWNED SHALL begin at edge N+1 with gnt/sel of the winner; latency is one cycle.
REQ-014 In IDLE with req zero, the block SHALL stay in IDLE with outputs zero.
REQ-015 In OWNED while req[owner]=1 and no timeout, the grant SHALL hold unchanged.
REQ-016 In OWNED when req[owner]=0, the block SHALL pass to the round-robin winner among the other req bits at the next edge, with no idle bubble. If no other req bit is set, it SHALL go to IDLE.
REQ-017 A 8-bit hold counter SHALL clear on each new grant and increment on each OWNED cycle. It SHALL saturate at MAX_HOLD-1.
REQ-018 `MUXARB_TIMEOUT_EN` controls timeout handover:
- Condition: counter = MAX_HOLD-1, req[owner]=1, and any other req bit set.
- Action: the grant SHALL pass at the next edge to the round-robin winner excluding the owner.
- preempt SHALL be high for exactly that first cycle of the new grant.
REQ-019 At counter saturation with no other requester pending, the owner SHALL keep the grant and preempt SHALL stay low.
REQ-020 If the owner drops req in the same cycle a timeout would fire, it SHALL count as a normal release and preempt SHALL stay low.
REQ-021 A requester that loses its grant SHALL be eligible again through normal round-robin order.

Reset
REQ-022 When reset is asserted:
- Outputs SHALL go to zero asynchronously: gnt=0, sel=0, sel_valid=0, preempt=0.
- State SHALL go to IDLE, ptr to 0, hold counter to 0.
REQ-023 Reset asserted mid-ownership SHALL drop the grant immediately, without waiting for a clock edge.
REQ-024 After reset deasserts, the first arbitration SHALL start from ptr=0.

Configuration
REQ-025 With macro MUXARB_TIMEOUT_EN defined, REQ-018 and REQ-019 SHALL apply and the hold counter SHALL be present.
REQ-026 Without MUXARB_TIMEOUT_EN:
- The hold counter SHALL be omitted.
- The owner SHALL keep the grant until it drops req.
- preempt SHALL be tied to 0.
- MAX_HOLD SHALL be ignored.

Verification
REQ-027 Reset release with req=8'b0000_0000 for 5 cycles -> gnt=0, sel_valid=0 throughout.
REQ-028 Round-robin order: req=8'b1000_0101 held, each owner drops req for one cycle after 2 owned cycles -> grant order 0,2,7,0 with sel=0,2,7,0 and no idle cycle between owners.
REQ-029 Timeout (macro on, MAX_HOLD=4): req=8'b0000_0011 held constantly -> owner 0 for 4 cycles, then owner 1 with preempt=1 for one cycle, then owner 0 after 4 more cycles.
REQ-030 Lone owner (macro on, MAX_HOLD=4): req=8'b0001_0000 held 20 cycles -> sel=4 throughout and preempt never asserts.
REQ-031 Async reset mid-grant: owner 3 active, reset pulsed between clock edges -> gnt=0 before the next edge; after release with req=8'b0000_1001, owner is 0.
REQ-032 Macro off with MAX_HOLD=4: req=8'b0000_0011 held 30 cycles -> owner 0 throughout and preempt=0.
